// File: rtl/priority_arbiter4_pkg.sv
// rtl/priority_arbiter4_pkg.sv - shared types and constants for the 4-way priority arbiter
//
// Purpose: state encoding, default tenure limit and a small decode helper
//          shared by priority_arbiter4 and its sub-module.
// Ports:   none (package).

package priority_arbiter4_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    GAP  = 2'd2
  } state_t;

  localparam int unsigned HOLD_MAX_DEFAULT = 15;

  // Index to one-hot grant vector.
  function automatic logic [3:0] onehot4(input logic [1:0] idx);
    logic [3:0] v;
    v = 4'b0000;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/priority_arbiter4_prio_enc4.sv
// rtl/priority_arbiter4_prio_enc4.sv - combinational 4-to-2 priority encoder, bit 3 wins
//
// Purpose: pick the highest-index set bit of the eligible request vector.
// Ports:
//   req   in  [3:0]  eligible request vector
//   idx   out [1:0]  index of the highest set bit (0 when none set)
//   valid out        any bit of req set

module prio_enc4
  import priority_arbiter4_pkg::*;
(
  input  logic [3:0] req,
  output logic [1:0] idx,
  output logic       valid
);

  always_comb begin
    idx   = 2'd0;
    valid = 1'b1;
    if (req[3])      idx = 2'd3;
    else if (req[2]) idx = 2'd2;
    else if (req[1]) idx = 2'd1;
    else if (req[0]) idx = 2'd0;
    else             valid = 1'b0;
  end

endmodule

// File: rtl/priority_arbiter4.sv
// rtl/priority_arbiter4.sv - 4-requester fixed-priority arbiter with tenure limit and timeout mask
//
// Purpose: grants one of four requesters (bit 3 highest) and holds the grant
//          without preemption until the owner releases or HOLD_MAX cycles
//          elapse. Every tenure is followed by a one-cycle GAP and an IDLE
//          arbitration cycle. A timed-out owner is excluded from the next
//          arbitration only.
// Parameters:
//   HOLD_MAX  maximum consecutive grant cycles per tenure (1..255)
// Ports:
//   clk        in        clock, rising edge
//   rst        in        asynchronous active-high reset
//   req        in  [3:0] request vector
//   gnt        out [3:0] registered one-hot grant, zero when idle
//   gnt_id     out [1:0] index of granted requester, zero when not valid
//   gnt_valid  out       a grant is active
//   timeout    out       one-cycle pulse when a tenure was ended by HOLD_MAX

module priority_arbiter4
  import priority_arbiter4_pkg::*;
#(
  parameter int unsigned HOLD_MAX = HOLD_MAX_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] gnt_id,
  output logic       gnt_valid,
  output logic       timeout
);

  localparam logic [7:0] HOLD_MAX8 = 8'(HOLD_MAX);

  state_t     state, state_next;
  logic [7:0] cnt, cnt_next;
  logic [3:0] mask, mask_next;
  logic [3:0] gnt_next;
  logic [1:0] gnt_id_next;
  logic       gnt_valid_next;
  logic       timeout_next;

  logic [3:0] eligible;
  logic [1:0] enc_idx;
  logic       enc_valid;
  logic [7:0] cnt_inc;

  // The mask is only ever non-zero between a timeout and the following
  // IDLE arbitration, so it can be applied unconditionally here.
  assign eligible = req & ~mask;
  assign cnt_inc  = cnt + 8'd1;

  prio_enc4 u_enc (
    .req   (eligible),
    .idx   (enc_idx),
    .valid (enc_valid)
  );

  always_comb begin
    state_next     = state;
    cnt_next       = cnt;
    mask_next      = mask;
    gnt_next       = 4'b0000;
    gnt_id_next    = 2'd0;
    gnt_valid_next = 1'b0;
    timeout_next   = 1'b0;

    case (state)
      IDLE: begin
        // Every IDLE arbitration consumes the mask, whether or not it grants.
        mask_next = 4'b0000;
        if (enc_valid) begin
          state_next     = BUSY;
          cnt_next       = 8'd0;
          gnt_next       = onehot4(enc_idx);
          gnt_id_next    = enc_idx;
          gnt_valid_next = 1'b1;
        end
      end

      BUSY: begin
        // Release takes precedence over the limit: a drop on the same edge
        // the limit is reached is a normal release with no timeout/mask.
        if (!req[gnt_id]) begin
          state_next = GAP;
          cnt_next   = 8'd0;
        end else if (cnt_inc == HOLD_MAX8) begin
          state_next   = GAP;
          cnt_next     = 8'd0;
          timeout_next = 1'b1;
          mask_next    = gnt;
        end else begin
          cnt_next       = cnt_inc;
          gnt_next       = gnt;
          gnt_id_next    = gnt_id;
          gnt_valid_next = 1'b1;
        end
      end

      GAP: begin
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
        cnt_next   = 8'd0;
        mask_next  = 4'b0000;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= 8'd0;
      mask      <= 4'b0000;
      gnt       <= 4'b0000;
      gnt_id    <= 2'd0;
      gnt_valid <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      mask      <= mask_next;
      gnt       <= gnt_next;
      gnt_id    <= gnt_id_next;
      gnt_valid <= gnt_valid_next;
      timeout   <= timeout_next;
    end
  end

endmodule

// File: tb/tb_priority_arbiter4.sv
// tb/tb_priority_arbiter4.sv - directed self-checking bench for priority_arbiter4

module tb_priority_arbiter4;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic       gnt_valid;
  logic       timeout;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  priority_arbiter4 #(.HOLD_MAX(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .gnt       (gnt),
    .gnt_id    (gnt_id),
    .gnt_valid (gnt_valid),
    .timeout   (timeout)
  );

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got gnt/id/v/to=%b want %b", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] outs();
    return {gnt, gnt_id, gnt_valid, timeout};
  endfunction

  // At the falling edge: compare outputs, then present the next request.
  task automatic tick(input string tag, input logic [3:0] eg, input logic [1:0] eid,
                      input logic et, input logic [3:0] nreq);
    @(negedge clk);
    check(tag, outs(), {eg, eid, (eg != 4'b0000), et});
    req = nreq;
  endtask

  initial begin
    rst = 1'b1;
    req = 4'b0000;
    #3;
    check("reset", outs(), 8'h00);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    req = 4'b0100;

    // single request, latency 1
    tick("r26_grant", 4'b0100, 2'd2, 1'b0, 4'b0000);
    tick("r26_gap",   4'b0000, 2'd0, 1'b0, 4'b0000);
    tick("r26_idle",  4'b0000, 2'd0, 1'b0, 4'b0001);

    // no preemption; release on the edge the limit would be hit
    tick("r27_g0",    4'b0001, 2'd0, 1'b0, 4'b1001);
    tick("r27_hold1", 4'b0001, 2'd0, 1'b0, 4'b1001);
    tick("r27_hold2", 4'b0001, 2'd0, 1'b0, 4'b1000);
    tick("r27_gap",   4'b0000, 2'd0, 1'b0, 4'b1000);
    tick("r27_idle",  4'b0000, 2'd0, 1'b0, 4'b1000);
    tick("r27_g3",    4'b1000, 2'd3, 1'b0, 4'b0000);
    tick("r27_gap2",  4'b0000, 2'd0, 1'b0, 4'b0000);
    tick("r27_idle2", 4'b0000, 2'd0, 1'b0, 4'b1010);

    // timeout masks bit 3, bit 1 wins next
    tick("r28_c1",    4'b1000, 2'd3, 1'b0, 4'b1010);
    tick("r28_c2",    4'b1000, 2'd3, 1'b0, 4'b1010);
    tick("r28_c3",    4'b1000, 2'd3, 1'b0, 4'b1010);
    tick("r28_to",    4'b0000, 2'd0, 1'b1, 4'b1010);
    tick("r28_idle",  4'b0000, 2'd0, 1'b0, 4'b1010);
    tick("r28_g1",    4'b0010, 2'd1, 1'b0, 4'b0000);
    tick("r28_gap",   4'b0000, 2'd0, 1'b0, 4'b0000);
    tick("r28_idle2", 4'b0000, 2'd0, 1'b0, 4'b0001);

    // sole requester times out: one extra masked idle cycle
    tick("r29_c1",    4'b0001, 2'd0, 1'b0, 4'b0001);
    tick("r29_c2",    4'b0001, 2'd0, 1'b0, 4'b0001);
    tick("r29_c3",    4'b0001, 2'd0, 1'b0, 4'b0001);
    tick("r29_to",    4'b0000, 2'd0, 1'b1, 4'b0001);
    tick("r29_idle",  4'b0000, 2'd0, 1'b0, 4'b0001);
    tick("r29_mskd",  4'b0000, 2'd0, 1'b0, 4'b0001);
    tick("r29_regnt", 4'b0001, 2'd0, 1'b0, 4'b0000);
    tick("r29_gap",   4'b0000, 2'd0, 1'b0, 4'b0000);
    tick("r29_idle2", 4'b0000, 2'd0, 1'b0, 4'b0100);

    // drop on the limit edge: no timeout, no mask
    tick("r30_c1",    4'b0100, 2'd2, 1'b0, 4'b0100);
    tick("r30_c2",    4'b0100, 2'd2, 1'b0, 4'b0100);
    tick("r30_c3",    4'b0100, 2'd2, 1'b0, 4'b0000);
    tick("r30_gap",   4'b0000, 2'd0, 1'b0, 4'b0100);
    tick("r30_idle",  4'b0000, 2'd0, 1'b0, 4'b0100);
    tick("r30_nomsk", 4'b0100, 2'd2, 1'b0, 4'b0100);

    // asynchronous reset mid-tenure
    #2;
    rst = 1'b1;
    #1;
    check("r31_async", outs(), 8'h00);
    @(negedge clk);
    check("r31_inrst", outs(), 8'h00);
    rst = 1'b0;
    tick("r31_regnt", 4'b0100, 2'd2, 1'b0, 4'b0000);
    tick("r31_gap",   4'b0000, 2'd0, 1'b0, 4'b0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/priority_arbiter4.md
PRIORITY_ARBITER4 -- requirements
Module: priority_arbiter4

Interface
REQ-001 Parameter HOLD_MAX, default 15, maximum consecutive grant cycles per tenure (legal range 1..255).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 req  input  4  request vector; bit 3 highest priority, bit 0 lowest.
REQ-005 gnt  output 4  registered one-hot grant, all-zero when none.
REQ-006 gnt_id  output 2  encoded index of granted requester; 0 when gnt_valid low.
REQ-007 gnt_valid  output 1  high while any grant is active.
REQ-008 timeout  output 1  one-cycle pulse when a tenure is forcibly ended by HOLD_MAX.

Function
REQ-009 FSM states: IDLE, BUSY, GAP; exactly one active at a time.
REQ-010 IDLE: at an edge where any eligible req bit is high, SHALL enter BUSY and grant the highest-index eligible bit; gnt visible the cycle after req sampled (latency 1).
REQ-011 IDLE with no eligible req: SHALL stay IDLE, gnt=0, gnt_valid=0, gnt_id=0.
REQ-012 Eligible = req bit high and not masked (REQ-016).
REQ-013 BUSY: grant SHALL be held unchanged regardless of higher-priority requests (no preemption by priority).
REQ-014 BUSY: when req[gnt_id] sampled low, SHALL enter GAP; gnt drops the following cycle.
REQ-015 BUSY: 8-bit hold counter cleared on grant, increments each BUSY cycle; when it reaches HOLD_MAX with req[gnt_id] still high, SHALL enter GAP and pulse timeout for exactly the first GAP cycle.
REQ-016 After a timeout, the timed-out requester SHALL be masked for the next arbitration only; mask clears when that arbitration grants someone or finds no eligible request.
REQ-017 If the timed-out requester is the only one requesting, mask still applies for that arbitration: one extra idle cycle, then it is re-granted.
REQ-018 GAP: lasts exactly one cycle, gnt=0, gnt_valid=0, then IDLE.
REQ-019 Request drop and HOLD_MAX reached on the same edge: treated as normal release, timeout SHALL NOT pulse, no mask.
REQ-020 Minimum turnaround between two grants: 2 cycles with all outputs zero (GAP + IDLE sample).
REQ-021 gnt, gnt_id, gnt_valid SHALL always be mutually consistent (gnt = one-hot of gnt_id when valid).

Reset
REQ-022 rst high SHALL immediately force IDLE, gnt=0, gnt_id=0, gnt_valid=0, timeout=0, counter=0, mask cleared.
REQ-023 rst asserted mid-tenure SHALL drop the grant asynchronously; first arbitration at the first edge after rst deasserts.

Structure
REQ-024 Shared package holds state encoding (IDLE=0, BUSY=1, GAP=2, 2 bits) and HOLD_MAX default constant.
REQ-025 One sub-module, prio_enc4: combinational 4-to-2 priority encoder over eligible req, outputs index and valid; instantiated once.

Verification
REQ-026 rst released, req=0100 -> next cycle gnt=0100, gnt_id=2, gnt_valid=1.
REQ-027 Holding gnt=0001, raise req=1001 -> gnt stays 0001 until req[0] drops; then 2 zero cycles, then gnt=1000.
REQ-028 HOLD_MAX=3, req=1010 held -> gnt=1000 for 3 cycles, timeout pulse 1 cycle, then gnt=0010 (bit 3 masked).
REQ-029 HOLD_MAX=3, req=0001 held -> 3-cycle grant, timeout, GAP, masked IDLE cycle, then gnt=0001 re-granted.
REQ-030 req[2] drops on the same edge HOLD_MAX reached -> timeout stays 0, normal GAP.
REQ-031 rst pulsed while gnt=0100 -> gnt=0000 without waiting for clk edge; req=0100 after release -> re-granted 1 cycle later.
